// File: rtl/dlx_mem_responder.sv
// DLX data-memory responder: wait-stated single-port word storage.
// Optional address checking enabled by defining DLX_MEMRESP_ERR_EN.
module dlx_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 6
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];

  logic                  accept;
  logic                  enter_ack;
  logic                  in_err;
  logic                  cur_we;
  logic                  cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           cur_wdata;

`ifdef DLX_MEMRESP_ERR_EN
  assign in_err = (|addr_i[1:0])
                | (|addr_i[31:DEPTH_LOG2+2]);
`else
  logic unused_bits;
  assign in_err = 1'b0;
  assign unused_bits = ^{addr_i[1:0],
                         addr_i[31:DEPTH_LOG2+2],
                         err_q};
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  // With zero wait states the access completes on the accepting
  // edge, so the live inputs stand in for the captured copy.
  always_comb begin
    accept    = (state_q == IDLE) && req_i;
    cur_we    = accept ? we_i : we_q;
    cur_idx   = accept ? addr_i[DEPTH_LOG2+1:2] : idx_q;
    cur_wdata = accept ? wdata_i : wdata_q;
    cur_err   = accept ? in_err : err_q;
    enter_ack = (accept && WAIT_CYCLES == 0)
              || (state_q == WAIT && cnt_q == 4'd1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = mem_q[i];
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[DEPTH_LOG2+1:2];
          wdata_d = wdata_i;
          err_d   = in_err;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_ack) begin
      if (cur_we) begin
        if (!cur_err)
          mem_d[cur_idx] = cur_wdata;
      end else begin
        rdata_d = cur_err ? 32'h0 : mem_q[cur_idx];
      end
    end
  end

  always_comb begin
    ack_o   = (state_q == ACK);
    busy_o  = (state_q != IDLE);
    rdata_o = rdata_q;
`ifdef DLX_MEMRESP_ERR_EN
    err_o   = (state_q == ACK) && err_q;
`else
    err_o   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Bench for dlx_mem_responder: vector table, streaming and reset cases.
// Expectations follow DLX_MEMRESP_ERR_EN when it is defined.
module tb_dlx_mem_responder;

  localparam int W = 2;

`ifdef DLX_MEMRESP_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, err;
  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ack0, busy0, err0;

  always #5 clk = ~clk;

  dlx_mem_responder #(.WAIT_CYCLES(W), .DEPTH_LOG2(6)) dut (
    .clock_i(clk), .reset_i(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
    .ack_o(ack), .busy_o(busy), .err_o(err)
  );

  dlx_mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dut0 (
    .clock_i(clk), .reset_i(rst), .req_i(req0), .we_i(we0),
    .addr_i(addr0), .wdata_i(wdata0), .rdata_o(rdata0),
    .ack_o(ack0), .busy_o(busy0), .err_o(err0)
  );

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t q[$];
  exp_t q0[$];
  vec_t tbl[11];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic we_in,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] exp_rd,
                        input logic exp_err,
                        input bit glitch);
    int   k;
    int   bcnt;
    bit   got;
    exp_t e;
    @(negedge clk);
    chk("idle_before", 32'(busy), 32'd0);
    req = 1'b1; we = we_in; addr = a; wdata = wd;
    q.push_back('{we_in, exp_rd, exp_err});
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    if (glitch) begin
      req = 1'b1; we = 1'b1;
      addr = a + 32'd4; wdata = 32'h22222222;
    end
    k = 0; bcnt = 0; got = 0;
    while (!got && k < 20) begin
      if (busy) bcnt++;
      if (ack) begin
        got = 1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        chk("latency", 32'(k + 1), 32'(W + 1));
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: got ack expected none");
        end else begin
          e = q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", 32'(err), 32'(e.err));
        end
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout: got no ack expected ack");
      req = 1'b0;
    end
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("busy_cycles", 32'(bcnt), 32'(W + 1));
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int   idx, acks, bad, n, nack;
    logic prev;
    logic [31:0] last;
    exp_t e;

    tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h018, 32'h0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h100, 32'h12345678, 32'h0, E};
    tbl[4]  = '{1'b0, 32'h000, 32'h0,
                E ? 32'h0 : 32'h12345678, 1'b0};
    tbl[5]  = '{1'b1, 32'h102, 32'h55,
                E ? 32'h0 : 32'h12345678, E};
    tbl[6]  = '{1'b0, 32'h000, 32'h0,
                E ? 32'h0 : 32'h55, 1'b0};
    tbl[7]  = '{1'b0, 32'h104, 32'h0, 32'h0, E};
    tbl[8]  = '{1'b1, 32'h0FC, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0FC, 32'h0, 32'hFFFFFFFF, 1'b0};
    tbl[10] = '{1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0};

    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    rst = 1'b0;

    // zero-wait instance with req held high throughout
    idx = 0; acks = 0; bad = 0; n = 0;
    prev = 1'b0; last = 32'h0;
    @(negedge clk);
    while (acks < 8 && n < 40) begin
      if (ack0) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL stream_extra_ack: got ack expected none");
        end else begin
          e = q0.pop_front();
          chk("stream_rdata", rdata0, e.rdata);
          chk("stream_err", 32'(err0), 32'(e.err));
        end
        acks++;
      end
      if (n > 0 && ack0 == prev) bad++;
      prev = ack0;
      if (!busy0 && idx < 8) begin
        req0 = 1'b1;
        addr0 = 32'h0;
        if (idx % 2 == 0) begin
          we0 = 1'b1;
          wdata0 = 32'(idx / 2 + 1);
          q0.push_back('{1'b1, last, 1'b0});
        end else begin
          we0 = 1'b0;
          wdata0 = 32'h0;
          last = 32'(idx / 2 + 1);
          q0.push_back('{1'b0, last, 1'b0});
        end
        idx++;
      end
      @(negedge clk);
      n++;
    end
    req0 = 1'b0;
    chk("stream_acks", 32'(acks), 32'd8);
    chk("stream_alternate", 32'(bad), 32'd0);
    chk("stream_leftover", 32'(q0.size()), 32'd0);

    for (int i = 0; i < 11; i++)
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].rdata, tbl[i].err, 1'b0);

    // request changes during WAIT must not leak into the access
    access(1'b1, 32'h20, 32'h11111111,
           32'hDEADBEEF, 1'b0, 1'b1);
    access(1'b0, 32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
    access(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b0);

    // reset in WAIT aborts a pending write
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) nack++;
    end
    chk("no_ack_after_rst", 32'(nack), 32'd0);
    chk("rdata_after_rst", rdata, 32'h0);
    access(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    access(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
